conv_output_stage: RTL and testbench
====================================

Name: conv_output_stage

Overview:
- Downstream consumer of the 64-input adder tree and its sequential accumulator.
- Counts the accumulated chunks per output pixel and captures the final sum once the last chunk arrives.
- Adds a per-layer bias with signed saturation, optionally applies ReLU, and buffers pixels in a small FWFT FIFO with a valid/ready interface to output memory.
- Issues the clear pulse for the tree accumulator between pixels and tracks overflow stickily.

Parameters:
- N, 32, data width; signed two's complement.
- AW, 3, FIFO address width; depth = 2^AW = 8.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; latches config and begins a run.
- cfg_num_chunks  input  8  accumulations per pixel; 0 treated as 1.
- cfg_num_pixels  input  16  pixels per run; 0 treated as 1.
- bias  input  N  signed bias, latched on start.
- sum_in  input  N  signed accumulated sum from the adder tree.
- sum_valid  input  1  qualifies sum_in; counted only while in_ready=1.
- overflow_in  input  1  adder-tree overflow, qualified by sum_valid.
- in_ready  output  1  high only in ACCUM.
- local_reset_out  output  1  one-cycle clear pulse to the tree accumulator.
- out_data  output  N  FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer pop; pops when out_valid && out_ready.
- fifo_count  output  AW+1  current occupancy.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last pixel is written.
- ovf_flag  output  1  sticky overflow indicator.

Behaviour:
- Reset (async): state=IDLE, all counters=0, FIFO empty.
  - All outputs are 0: in_ready, local_reset_out, out_valid, out_data, fifo_count, busy, done, ovf_flag.
  - Reset mid-run discards every pixel, buffered or in flight.
- IDLE:
  - On start: latch chunks, pixels and bias (0 mapped to 1); clear ovf_flag; clear chunk_cnt and pix_cnt; go to ACCUM.
  - start while busy is ignored.
- ACCUM:
  - Each accepted sum_valid increments chunk_cnt.
  - On the accepted beat where chunk_cnt == chunks-1: register sum_in into acc_r, go to BIAS.
  - overflow_in with sum_valid sets ovf_flag.
- BIAS (1 cycle):
  - res_r = sat(acc_r + bias_r) using an (N+1)-bit signed sum.
  - Clamp to 2^(N-1)-1 or -2^(N-1); any clamp sets ovf_flag.
  - Apply ReLU per the optional feature. Go to PUSH.
- PUSH:
  - If the FIFO is not full, or a pop occurs in the same cycle: write res_r, pulse local_reset_out, increment pix_cnt, clear chunk_cnt.
  - Then go to DONE if pix_cnt == pixels-1, else ACCUM.
  - If full with no pop: stay in PUSH; no local_reset_out, in_ready=0.
- DONE: done=1 for one cycle, then IDLE.
- Latency: final sum_valid accepted at edge T -> BIAS in T+1 -> PUSH/write at edge T+2 -> out_valid=1 after T+2 if the FIFO was empty.
- FIFO:
  - FWFT; out_data = head.
  - Simultaneous read and write leaves the count unchanged.
  - Read when empty is ignored.
  - Pointers wrap modulo 2^AW.
  - FIFO contents survive DONE and a subsequent start.

Optional Feature:
- CONV_OUT_RELU_EN defined: in BIAS, a negative saturated result is replaced by 0; clamping still sets ovf_flag.
- Undefined: the signed saturated result passes unchanged.

Test Plan:
- chunks=3, pixels=1, bias=5, sums 10/20/30 (final 30) -> out_data=35; one local_reset_out pulse; done 1 cycle after the write.
- chunks=1, bias=1, final=0x7FFFFFFF -> out_data=0x7FFFFFFF, ovf_flag=1; with bias=-1 and final=0x80000000 -> 0x80000000, ovf_flag=1.
- CONV_OUT_RELU_EN, final=-100, bias=40 -> out_data=0; without the macro -> out_data=0xFFFFFFC4 (-60).
- pixels=10, out_ready=0 -> fifo_count reaches 8, state holds in PUSH, in_ready=0; raise out_ready -> all 10 pixels emitted in order, done asserted once.
- overflow_in=1 on one accepted beat -> ovf_flag stays 1 until the next start; sum_valid while in_ready=0 is not counted.
- Assert reset during BIAS with 2 entries buffered -> all outputs 0, fifo_count=0; a new start runs cleanly.

Source files
------------

// File: rtl/conv_output_stage.sv
// conv_output_stage: per-pixel chunk counter, bias add with signed saturation,
// optional ReLU, and an 8-entry FWFT output FIFO with valid/ready handshake.
// Optional feature macro: CONV_OUT_RELU_EN (clamp negative results to zero).
module conv_output_stage #(
  parameter int unsigned N  = 32,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    cfg_num_chunks,
  input  logic [15:0]   cfg_num_pixels,
  input  logic [N-1:0]  bias,
  input  logic [N-1:0]  sum_in,
  input  logic          sum_valid,
  input  logic          overflow_in,
  output logic          in_ready,
  output logic          local_reset_out,
  output logic [N-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   fifo_count,
  output logic          busy,
  output logic          done,
  output logic          ovf_flag
);

  localparam int unsigned CW    = 8;
  localparam int unsigned PW    = 16;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACCUM = 3'd1,
    S_BIAS  = 3'd2,
    S_PUSH  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  chunks_q, chunks_d;
  logic [PW-1:0]  pixels_q, pixels_d;
  logic [N-1:0]   bias_q, bias_d;
  logic [CW-1:0]  chunk_cnt_q, chunk_cnt_d;
  logic [PW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   res_q, res_d;
  logic           ovf_q, ovf_d;
  logic           in_ready_q, in_ready_d;
  logic           lr_q, lr_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;

  logic           accept_c;
  logic           pop_c;
  logic           push_c;
  logic [N:0]     sum_wide_c;
  logic           clamp_c;
  logic [N-1:0]   sat_c;
  logic [N-1:0]   res_next_c;

  // Handshake qualifiers; a full FIFO may still take a write when it pops the same cycle
  assign accept_c = in_ready_q && sum_valid;
  assign pop_c    = (count_q != '0) && out_ready;
  assign push_c   = (state_q == S_PUSH) && (!count_q[AW] || pop_c);

  // Sign-extended bias add with saturation, then optional ReLU
  always_comb begin
    sum_wide_c = {acc_q[N-1], acc_q} + {bias_q[N-1], bias_q};
    clamp_c    = sum_wide_c[N] ^ sum_wide_c[N-1];
    if (clamp_c) begin
      sat_c = sum_wide_c[N] ? SAT_MIN : SAT_MAX;
    end else begin
      sat_c = sum_wide_c[N-1:0];
    end
`ifdef CONV_OUT_RELU_EN
    res_next_c = sat_c[N-1] ? '0 : sat_c;
`else
    res_next_c = sat_c;
`endif
  end

  // Control FSM: next state, datapath captures and next values of registered outputs
  always_comb begin
    state_d     = state_q;
    chunks_d    = chunks_q;
    pixels_d    = pixels_q;
    bias_d      = bias_q;
    chunk_cnt_d = chunk_cnt_q;
    pix_cnt_d   = pix_cnt_q;
    acc_d       = acc_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          chunks_d    = (cfg_num_chunks == '0) ? CW'(1) : cfg_num_chunks;
          pixels_d    = (cfg_num_pixels == '0) ? PW'(1) : cfg_num_pixels;
          bias_d      = bias;
          ovf_d       = 1'b0;
          chunk_cnt_d = '0;
          pix_cnt_d   = '0;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept_c) begin
          chunk_cnt_d = chunk_cnt_q + CW'(1);
          if (overflow_in) begin
            ovf_d = 1'b1;
          end
          if (chunk_cnt_q == chunks_q - CW'(1)) begin
            acc_d   = sum_in;
            state_d = S_BIAS;
          end
        end
      end
      S_BIAS: begin
        res_d = res_next_c;
        if (clamp_c) begin
          ovf_d = 1'b1;
        end
        state_d = S_PUSH;
      end
      S_PUSH: begin
        if (push_c) begin
          pix_cnt_d   = pix_cnt_q + PW'(1);
          chunk_cnt_d = '0;
          state_d     = (pix_cnt_q == pixels_q - PW'(1)) ? S_DONE : S_ACCUM;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_ACCUM);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
    lr_d       = push_c;
  end

  // Control and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      chunks_q    <= '0;
      pixels_q    <= '0;
      bias_q      <= '0;
      chunk_cnt_q <= '0;
      pix_cnt_q   <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      lr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunks_q    <= chunks_d;
      pixels_q    <= pixels_d;
      bias_q      <= bias_d;
      chunk_cnt_q <= chunk_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      lr_q        <= lr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // FIFO pointer and occupancy next state; pointers wrap naturally at AW bits
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_c && pop_c) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // FIFO storage and pointers; storage clears on reset so the head reads 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= res_q;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign local_reset_out = lr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign ovf_flag        = ovf_q;
  assign out_data        = mem_q[rd_ptr_q];
  assign out_valid       = (count_q != '0);
  assign fifo_count      = count_q;

endmodule

// File: tb/tb_conv_output_stage.sv
// Testbench for conv_output_stage: vector table plus hand-written latency,
// backpressure, sticky-overflow and mid-run reset sequences; outputs are
// checked against a scoreboard of expected pixels.
module tb_conv_output_stage;

  localparam int N  = 32;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    cfg_num_chunks;
  logic [15:0]   cfg_num_pixels;
  logic [N-1:0]  bias;
  logic [N-1:0]  sum_in;
  logic          sum_valid;
  logic          overflow_in;
  logic          in_ready;
  logic          local_reset_out;
  logic [N-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   fifo_count;
  logic          busy;
  logic          done;
  logic          ovf_flag;

  conv_output_stage #(.N(N), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_num_chunks  (cfg_num_chunks),
    .cfg_num_pixels  (cfg_num_pixels),
    .bias            (bias),
    .sum_in          (sum_in),
    .sum_valid       (sum_valid),
    .overflow_in     (overflow_in),
    .in_ready        (in_ready),
    .local_reset_out (local_reset_out),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .fifo_count      (fifo_count),
    .busy            (busy),
    .done            (done),
    .ovf_flag        (ovf_flag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  int lr_cnt = 0;
  int done_cnt = 0;

  // Observe pops, clear pulses and done pulses midway between active edges
  always @(negedge clk) begin
    if (!reset) begin
      if (local_reset_out) lr_cnt <= lr_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  typedef struct {
    logic [7:0]   ch;
    logic [15:0]  px;
    logic [N-1:0] b;
    logic [N-1:0] fin;
    logic [N-1:0] want;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [N-1:0] relu_model(input logic [N-1:0] x);
`ifdef CONV_OUT_RELU_EN
    return x[N-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] ch, input logic [15:0] px, input logic [N-1:0] b);
    cfg_num_chunks = ch;
    cfg_num_pixels = px;
    bias = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed one pixel's chunks; junk drives sum_valid/overflow_in while in_ready is low
  task automatic feed_pixel(input int ch, input logic [N-1:0] fin, input logic [N-1:0] want,
                            input bit junk, input int ovf_beat);
    int budget;
    for (int i = 0; i < ch; i++) begin
      budget = 0;
      while (!in_ready) begin
        sum_valid = junk;
        overflow_in = junk;
        sum_in = 32'hDEAD_BEEF;
        tick();
        budget++;
        if (budget > 200) begin
          fail_timeout("in_ready_wait");
          sum_valid = 1'b0;
          overflow_in = 1'b0;
          return;
        end
      end
      sum_valid = 1'b1;
      sum_in = (i == ch - 1) ? fin : N'(10 * (i + 1));
      overflow_in = (i == ovf_beat);
      if (i == ch - 1) exp_q.push_back(want);
      tick();
    end
    sum_valid = 1'b0;
    overflow_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 400) begin
      tick();
      n++;
    end
    if (done_cnt == d0) fail_timeout(name);
  endtask

  // Compare everything the DUT emitted against the scoreboard, then require both empty
  task automatic drain(input string name);
    logic [N-1:0] g;
    logic [N-1:0] w;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected: got %0h required nothing", name, g);
      end else begin
        w = exp_q.pop_front();
        chk({name, "_data"}, 64'(g), 64'(w));
      end
    end
    chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({name, "_local_reset"}, 64'(local_reset_out), 64'd0);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_out_data"}, 64'(out_data), 64'd0);
    chk({name, "_fifo_count"}, 64'(fifo_count), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_ovf"}, 64'(ovf_flag), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lr0;
    int d0;
    int ech;
    int epx;

    vecs[0] = '{8'd3, 16'd1, 32'd5,          32'd30,         32'd35,         1'b0};
    vecs[1] = '{8'd1, 16'd1, 32'd1,          32'h7FFF_FFFF,  32'h7FFF_FFFF,  1'b1};
    vecs[2] = '{8'd1, 16'd1, 32'hFFFF_FFFF,  32'h8000_0000,  32'h8000_0000,  1'b1};
    vecs[3] = '{8'd1, 16'd1, 32'd40,         32'hFFFF_FF9C,  32'hFFFF_FFC4,  1'b0};
    vecs[4] = '{8'd0, 16'd0, 32'hFFFF_FFF9,  32'd1000,       32'd993,        1'b0};
    vecs[5] = '{8'd4, 16'd3, 32'd100,        32'hFFFF_FFCE,  32'd50,         1'b0};
    vecs[6] = '{8'd2, 16'd1, 32'h8000_0000,  32'h8000_0000,  32'h8000_0000,  1'b1};
    vecs[7] = '{8'd1, 16'd1, 32'h7FFF_FFFF,  32'h8000_0000,  32'hFFFF_FFFF,  1'b0};

    reset = 1'b1;
    start = 1'b0;
    cfg_num_chunks = '0;
    cfg_num_pixels = '0;
    bias = '0;
    sum_in = '0;
    sum_valid = 1'b0;
    overflow_in = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("por");
    tick();
    reset = 1'b0;
    tick();

    // Vector table: single- and multi-pixel runs with out_ready held high
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      ech = (vecs[v].ch == 0) ? 1 : int'(vecs[v].ch);
      epx = (vecs[v].px == 0) ? 1 : int'(vecs[v].px);
      lr0 = lr_cnt;
      d0 = done_cnt;
      start_run(vecs[v].ch, vecs[v].px, vecs[v].b);
      for (int p = 0; p < epx; p++) begin
        feed_pixel(ech, vecs[v].fin, relu_model(vecs[v].want), 1'b0, -1);
      end
      wait_done($sformatf("vec%0d_done", v));
      tick();
      tick();
      drain($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_ovf", v), 64'(ovf_flag), 64'(vecs[v].ovf));
      chk($sformatf("vec%0d_lr_pulses", v), 64'(lr_cnt - lr0), 64'(epx));
      chk($sformatf("vec%0d_done_pulses", v), 64'(done_cnt - d0), 64'd1);
      chk($sformatf("vec%0d_busy", v), 64'(busy), 64'd0);
    end

    // Latency: final beat at edge T, write at T+2, done and clear pulse right after
    out_ready = 1'b0;
    start_run(8'd1, 16'd1, 32'd5);
    sum_valid = 1'b1;
    sum_in = 32'd100;
    exp_q.push_back(32'd105);
    tick();
    sum_valid = 1'b0;
    @(negedge clk);
    chk("lat_t0_in_ready", 64'(in_ready), 64'd0);
    chk("lat_t0_busy", 64'(busy), 64'd1);
    chk("lat_t0_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("lat_t1_out_valid", 64'(out_valid), 64'd0);
    chk("lat_t1_local_reset", 64'(local_reset_out), 64'd0);
    @(negedge clk);
    chk("lat_t2_out_valid", 64'(out_valid), 64'd1);
    chk("lat_t2_local_reset", 64'(local_reset_out), 64'd1);
    chk("lat_t2_done", 64'(done), 64'd1);
    chk("lat_t2_fifo_count", 64'(fifo_count), 64'd1);
    @(negedge clk);
    chk("lat_t3_done", 64'(done), 64'd0);
    chk("lat_t3_local_reset", 64'(local_reset_out), 64'd0);
    chk("lat_t3_busy", 64'(busy), 64'd0);
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    drain("lat");

    // Backpressure: 10 pixels into an 8-deep FIFO with the consumer stalled
    out_ready = 1'b0;
    lr0 = lr_cnt;
    d0 = done_cnt;
    start_run(8'd2, 16'd10, 32'd0);
    for (int p = 0; p < 9; p++) begin
      feed_pixel(2, N'(p * 3 + 1), N'(p * 3 + 1), 1'b0, -1);
    end
    for (int k = 0; k < 10; k++) tick();
    chk("bp_fifo_full", 64'(fifo_count), 64'd8);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_lr_pulses", 64'(lr_cnt - lr0), 64'd8);
    out_ready = 1'b1;
    feed_pixel(2, N'(28), N'(28), 1'b0, -1);
    wait_done("bp_done");
    for (int k = 0; k < 4; k++) tick();
    drain("bp");
    chk("bp_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("bp_fifo_empty", 64'(fifo_count), 64'd0);

    // Junk beats while in_ready is low are not counted and do not raise overflow
    start_run(8'd3, 16'd2, 32'd0);
    feed_pixel(3, 32'd77, 32'd77, 1'b1, -1);
    feed_pixel(3, 32'd88, 32'd88, 1'b1, -1);
    wait_done("junk_done");
    tick();
    tick();
    drain("junk");
    chk("junk_ovf", 64'(ovf_flag), 64'd0);

    // Sticky overflow from one accepted beat, cleared only by the next start
    start_run(8'd3, 16'd2, 32'd0);
    feed_pixel(3, 32'd5, 32'd5, 1'b1, 1);
    feed_pixel(3, 32'd6, 32'd6, 1'b1, -1);
    wait_done("sticky_done");
    for (int k = 0; k < 5; k++) tick();
    drain("sticky");
    chk("sticky_ovf_held", 64'(ovf_flag), 64'd1);
    start_run(8'd1, 16'd1, 32'd0);
    chk("sticky_ovf_cleared", 64'(ovf_flag), 64'd0);
    feed_pixel(1, 32'd9, 32'd9, 1'b0, -1);
    wait_done("sticky2_done");
    tick();
    tick();
    drain("sticky2");

    // Reset while BIAS is active with two pixels buffered
    out_ready = 1'b0;
    start_run(8'd1, 16'd5, 32'd0);
    feed_pixel(1, 32'd11, 32'd11, 1'b0, -1);
    feed_pixel(1, 32'd22, 32'd22, 1'b0, -1);
    feed_pixel(1, 32'd33, 32'd33, 1'b0, -1);
    chk("rst_pre_fifo_count", 64'(fifo_count), 64'd2);
    chk("rst_pre_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    got_q.delete();
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    d0 = done_cnt;
    start_run(8'd2, 16'd2, 32'd3);
    feed_pixel(2, 32'd7, 32'd10, 1'b0, -1);
    feed_pixel(2, 32'hFFFF_FFFD, 32'd0, 1'b0, -1);
    wait_done("post_rst_done");
    tick();
    tick();
    drain("post_rst");
    chk("post_rst_ovf", 64'(ovf_flag), 64'd0);
    chk("post_rst_fifo", 64'(fifo_count), 64'd0);
    chk("post_rst_done_pulses", 64'(done_cnt - d0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
